// File: rtl/flappy_pkg.sv
// Geometry, game-state encoding and tube start positions shared by the game datapath blocks.
// The crash detector and the tube scroller both draw on these values.
package flappy_pkg;

  localparam int BIRD_X      = 180;
  localparam int BIRD_HALF   = 15;
  localparam int TUBE_HALF_W = 30;
  localparam int GAP_HALF_H  = 35;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } game_state_t;

  // Tubes start 220 apart so pairwise spacing mod 660 is 220 from the first frame
  localparam logic [9:0] INIT_X [3] = '{10'd250, 10'd470, 10'd690};
  localparam logic [9:0] INIT_Y [3] = '{10'd200, 10'd280, 10'd160};

endpackage

// File: rtl/tube_lane.sv
// One tube: x/y register pair that scrolls left per tick and respawns on the right.
// o_pass is a same-cycle flag for a tick that carries the tube across the score line.
import flappy_pkg::*;

module tube_lane #(
  parameter int STEP   = 2,
  parameter int SPAN   = 660,
  parameter int X_WRAP = 30,
  parameter int Y_BASE = 96,
  parameter int PASS_X = 135
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [9:0] i_init_x,
  input  logic [9:0] i_init_y,
  input  logic       i_tick,
  input  logic       i_reload,
  input  logic [7:0] i_lfsr_byte,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_pass
);

  localparam logic [9:0] L_WRAP_LIM = 10'(X_WRAP + STEP);
  localparam logic [9:0] L_STEP     = 10'(STEP);
  localparam logic [9:0] L_BACK     = 10'(SPAN - STEP);
  localparam logic [9:0] L_YBASE    = 10'(Y_BASE);
  localparam logic [9:0] L_PASS     = 10'(PASS_X);

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic [9:0] w_x_next;
  logic       w_wrap;

  // Wrap is decided on the old x, so the subtract path never underflows
  always_comb begin
    w_wrap   = (r_x < L_WRAP_LIM);
    w_x_next = w_wrap ? (r_x + L_BACK) : (r_x - L_STEP);
  end

  always_ff @(posedge clk) begin
    if (clr || i_reload) begin
      r_x <= i_init_x;
      r_y <= i_init_y;
    end else if (i_tick) begin
      r_x <= w_x_next;
      if (w_wrap) r_y <= L_YBASE + {2'b00, i_lfsr_byte};
    end
  end

  assign o_pass = i_tick && (r_x >= L_PASS) && (w_x_next < L_PASS);
  assign o_x    = r_x;
  assign o_y    = r_y;

endmodule

// File: rtl/tube_scroller.sv
// Game flow (IDLE/RUN/OVER), gap-height LFSR, score, and three scrolling tube lanes.
// Every output is a register; game_end only reaches state, never an output directly.
import flappy_pkg::*;

module tube_scroller #(
  parameter int         STEP      = 2,
  parameter int         SPAN      = 660,
  parameter int         X_WRAP    = 30,
  parameter int         Y_BASE    = 96,
  parameter int         PASS_X    = 135,
  parameter logic [9:0] LFSR_SEED = 10'h1A5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       game_end,
  output logic [9:0] tube1_x_pos,
  output logic [9:0] tube1_y_pos,
  output logic [9:0] tube2_x_pos,
  output logic [9:0] tube2_y_pos,
  output logic [9:0] tube3_x_pos,
  output logic [9:0] tube3_y_pos,
  output logic       running,
  output logic       score_pulse,
  output logic [7:0] score
);

  game_state_t r_state;
  logic [9:0]  r_lfsr;
  logic [9:0]  w_x [3];
  logic [9:0]  w_y [3];
  logic [2:0]  w_pass;
  logic [1:0]  w_npass;
  logic        w_tick;
  logic        w_reload;

  // A crash in the same cycle as a frame tick suppresses the move
  assign w_tick   = (r_state == RUN) && frame_tick && !game_end;
  assign w_reload = (r_state == OVER) && start;
  assign w_npass  = 2'(w_pass[0]) + 2'(w_pass[1]) + 2'(w_pass[2]);

  for (genvar g = 0; g < 3; g++) begin : g_lane
    tube_lane #(
      .STEP(STEP), .SPAN(SPAN), .X_WRAP(X_WRAP), .Y_BASE(Y_BASE), .PASS_X(PASS_X)
    ) u_lane (
      .clk        (clk),
      .clr        (clr),
      .i_init_x   (INIT_X[g]),
      .i_init_y   (INIT_Y[g]),
      .i_tick     (w_tick),
      .i_reload   (w_reload),
      .i_lfsr_byte(r_lfsr[7:0]),
      .o_x        (w_x[g]),
      .o_y        (w_y[g]),
      .o_pass     (w_pass[g])
    );
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= IDLE;
      running     <= 1'b0;
      r_lfsr      <= LFSR_SEED;
      score       <= 8'd0;
      score_pulse <= 1'b0;
    end else begin
      score_pulse <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= RUN;
          running <= 1'b1;
        end
        RUN: if (game_end) begin
          r_state <= OVER;
          running <= 1'b0;
        end else if (frame_tick) begin
          r_lfsr      <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
          score       <= score + {6'd0, w_npass};
          score_pulse <= |w_pass;
        end
        OVER: if (start) begin
          r_state <= IDLE;
          r_lfsr  <= LFSR_SEED;
          score   <= 8'd0;
        end
        default: begin
          r_state <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  assign tube1_x_pos = w_x[0];
  assign tube1_y_pos = w_y[0];
  assign tube2_x_pos = w_x[1];
  assign tube2_y_pos = w_y[1];
  assign tube3_x_pos = w_x[2];
  assign tube3_y_pos = w_y[2];

endmodule

// File: tb/tb_tube_scroller.sv
// Bench for tube_scroller: vector table, directed corner sequences and random traffic
// all compared every cycle against an arithmetic model of the game rules.
module tb_tube_scroller;

  logic       clk = 1'b0;
  logic       clr = 1'b0, frame_tick = 1'b0, start = 1'b0, game_end = 1'b0;
  logic [9:0] t1x, t1y, t2x, t2y, t3x, t3y;
  logic       running, score_pulse;
  logic [7:0] score;

  tube_scroller dut (
    .clk(clk), .clr(clr), .frame_tick(frame_tick), .start(start), .game_end(game_end),
    .tube1_x_pos(t1x), .tube1_y_pos(t1y), .tube2_x_pos(t2x), .tube2_y_pos(t2y),
    .tube3_x_pos(t3x), .tube3_y_pos(t3y), .running(running),
    .score_pulse(score_pulse), .score(score)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: game state 0=idle 1=run 2=over, positions as plain integers
  int         ms, mscore;
  int         mx [3];
  int         my [3];
  bit         mpulse;
  logic [9:0] mlfsr;
  localparam logic [9:0] SEED = 10'h1A5;

  function automatic logic [9:0] lfsr_adv(input int n);
    logic [9:0] v = SEED;
    for (int i = 0; i < n; i++) v = {v[8:0], v[9] ^ v[6]};
    return v;
  endfunction

  task automatic model_init();
    mx = '{250, 470, 690};
    my = '{200, 280, 160};
    mscore = 0;
    mlfsr  = SEED;
  endtask

  task automatic model_step(input bit c, input bit fr, input bit st, input bit ge);
    int nx, passes;
    mpulse = 1'b0;
    if (c) begin
      ms = 0;
      model_init();
    end else if (ms == 0) begin
      if (st) ms = 1;
    end else if (ms == 1) begin
      if (ge) ms = 2;
      else if (fr) begin
        passes = 0;
        for (int i = 0; i < 3; i++) begin
          // Positions live on a 660-wide ring from 30 to 689, moving 2 per tick
          nx = ((mx[i] - 30 - 2) % 660 + 660) % 660 + 30;
          if (nx > mx[i]) my[i] = 96 + int'(mlfsr[7:0]);
          if (mx[i] >= 135 && nx < 135) passes++;
          mx[i] = nx;
        end
        mscore = (mscore + passes) % 256;
        mpulse = (passes > 0);
        mlfsr  = {mlfsr[8:0], mlfsr[9] ^ mlfsr[6]};
      end
    end else if (st) begin
      ms = 0;
      model_init();
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model();
    logic [69:0] act, exp;
    act = {running, score_pulse, score, t1x, t1y, t2x, t2y, t3x, t3y};
    exp = {ms == 1, mpulse, 8'(mscore), 10'(mx[0]), 10'(my[0]), 10'(mx[1]), 10'(my[1]),
           10'(mx[2]), 10'(my[2])};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model_cmp @%0t: got %h expected %h", $time, act, exp);
    end
  endtask

  task automatic cycle(input bit c, input bit fr, input bit st, input bit ge);
    clr = c; frame_tick = fr; start = st; game_end = ge;
    @(posedge clk);
    #1;
    model_step(c, fr, st, ge);
    chk_model();
    clr = 1'b0; frame_tick = 1'b0; start = 1'b0; game_end = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit c, fr, st, ge;
    bit exp_run;
    int exp_score;
    int exp_x1;
  } tv_t;

  tv_t tv [11];

  initial begin
    int  k;
    bit  wrapped;
    int  prev_score;
    ms = 0;
    model_init();
    mpulse = 1'b0;

    tv[0]  = '{1, 0, 0, 0, 0, 0, 250};
    tv[1]  = '{1, 0, 0, 0, 0, 0, 250};
    tv[2]  = '{0, 1, 0, 0, 0, 0, 250};  // tick in IDLE does nothing
    tv[3]  = '{0, 0, 1, 1, 1, 0, 250};  // start beats game_end in IDLE
    tv[4]  = '{0, 1, 0, 0, 1, 0, 248};
    tv[5]  = '{0, 1, 0, 0, 1, 0, 246};
    tv[6]  = '{0, 0, 1, 0, 1, 0, 246};  // start ignored in RUN
    tv[7]  = '{0, 1, 0, 1, 0, 0, 246};  // crash wins over tick
    tv[8]  = '{0, 1, 0, 0, 0, 0, 246};
    tv[9]  = '{0, 0, 1, 0, 0, 0, 250};  // OVER -> IDLE reloads
    tv[10] = '{0, 1, 0, 0, 0, 0, 250};

    for (int i = 0; i < 11; i++) begin
      cycle(tv[i].c, tv[i].fr, tv[i].st, tv[i].ge);
      chk($sformatf("tv%0d_running", i), int'(running), int'(tv[i].exp_run));
      chk($sformatf("tv%0d_score", i), int'(score), tv[i].exp_score);
      chk($sformatf("tv%0d_x1", i), int'(t1x), tv[i].exp_x1);
    end
    chk("reset_y2", int'(t2y), 280);
    chk("reset_x3", int'(t3x), 690);

    // Scroll, pass and wrap on tube 1 from a fresh start
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(10);
    chk("scroll_x1", int'(t1x), 230);
    chk("scroll_x2", int'(t2x), 450);
    chk("scroll_x3", int'(t3x), 670);
    chk("scroll_pulse", int'(score_pulse), 0);
    ticks(47);
    chk("pre_pass_x1", int'(t1x), 136);
    ticks(1);
    chk("pass_x1", int'(t1x), 134);
    chk("pass_pulse", int'(score_pulse), 1);
    chk("pass_score", int'(score), 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pulse_one_cycle", int'(score_pulse), 0);
    ticks(52);
    chk("pre_wrap_x1", int'(t1x), 30);
    ticks(1);
    chk("wrap_x1", int'(t1x), 688);
    chk("wrap_y1", int'(t1y), 96 + int'(lfsr_adv(110) & 10'hFF));
    chk("spacing_12", (int'(t2x) - int'(t1x) + 660) % 660, 220);
    chk("spacing_23", (int'(t3x) - int'(t2x) + 660) % 660, 220);

    // Crash with a simultaneous tick, then frozen, then back to IDLE
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("crash_x1", int'(t1x), 688);
    chk("crash_running", int'(running), 0);
    ticks(5);
    chk("over_frozen_x2", int'(t2x), 248);
    chk("over_frozen_score", int'(score), 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("restart_x1", int'(t1x), 250);
    chk("restart_score", int'(score), 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);

    // Long run: enough ticks for the score to wrap
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    wrapped = 1'b0;
    prev_score = 0;
    for (k = 1; k <= 28500; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (t1x < 30 || t1x > 689 || t2x < 30 || t2x > 689 || t3x < 30 || t3x > 689 ||
          t1y < 96 || t1y > 351 || t2y < 96 || t2y > 351 || t3y < 96 || t3y > 351) begin
        n_fail++;
        $display("FAIL range tick %0d: x %0d %0d %0d y %0d %0d %0d required x 30..689 y 96..351",
                 k, t1x, t2x, t3x, t1y, t2y, t3y);
      end
      if (k % 3300 == 0) chk($sformatf("score_at_%0d", k), int'(score), (3 * (k / 330)) % 256);
      if (prev_score == 255 && score == 8'd0) wrapped = 1'b1;
      prev_score = int'(score);
    end
    chk("score_wrapped", int'(wrapped), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
